// File: rtl/gate_pack_pkg.sv
// Shared types for the bit packer: the buffered word entry and the length-width helper.
// Entries are sized for the widest legal word so one FIFO definition serves every WIDTH.
package gate_pack_pkg;

    localparam int MAX_WIDTH = 64;
    localparam int MAX_LEN_W = 7;

    typedef struct packed {
        logic [MAX_WIDTH-1:0] data;
        logic [MAX_LEN_W-1:0] len;
    } entry_t;

    function automatic int len_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/gate_pack_fifo2.sv
// Two-entry output buffer for packed words; a push into a full buffer succeeds only
// when a pop happens on the same edge.
module gate_pack_fifo2
    import gate_pack_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  logic   pop,
    input  entry_t wr_entry,
    output entry_t head,
    output logic   full,
    output logic   empty
);

    entry_t     mem [2];
    logic       rd_ptr;
    logic       wr_ptr;
    logic [1:0] count;
    logic       do_pop;
    logic       do_push;

    always_comb begin
        empty   = (count == 2'd0);
        full    = (count == 2'd2);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        head    = mem[rd_ptr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_entry;
    end

endmodule

// File: rtl/gate_bit_packer.sv
// Packs a stream of gated bit samples into WIDTH-bit words (first bit in bit 0),
// with flush of partial words, a 2-entry output buffer and sticky drop accounting.
module gate_bit_packer
    import gate_pack_pkg::*;
#(
    parameter  int WIDTH      = 8,
    parameter  int DROP_CNT_W = 8,
    localparam int LEN_W      = len_width(WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  in_bit,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [LEN_W-1:0]      out_len,
    output logic                  overflow,
    output logic [DROP_CNT_W-1:0] drop_count
);

    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(WIDTH);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_with;
    logic [LEN_W-1:0] fill;
    logic [LEN_W-1:0] fill_with;
    logic             emit;
    logic             pop;
    logic             drop;
    logic             fifo_full;
    logic             fifo_empty;
    logic             unused_head;
    entry_t           push_entry;
    entry_t           head;

    // Fold the same-cycle sample in first so completion and flush see the true count.
    always_comb begin
        acc_with        = acc | (WIDTH'(in_valid & in_bit) << fill);
        fill_with       = fill + LEN_W'(in_valid);
        emit            = (fill_with == FULL_LEN) || (flush && (fill_with != '0));
        push_entry.data = MAX_WIDTH'(acc_with);
        push_entry.len  = MAX_LEN_W'(fill_with);
        pop             = !fifo_empty && out_ready;
        drop            = emit && fifo_full && !pop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc  <= '0;
            fill <= '0;
        end else if (emit) begin
            acc  <= '0;
            fill <= '0;
        end else begin
            acc  <= acc_with;
            fill <= fill_with;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1) drop_count <= drop_count + DROP_CNT_W'(1);
        end
    end

    gate_pack_fifo2 u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (emit),
        .pop      (pop),
        .wr_entry (push_entry),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Entries are stored at maximum width; only the low WIDTH/LEN_W bits are meaningful.
    always_comb begin
        unused_head = ^head;
        out_valid   = !fifo_empty;
        out_data    = out_valid ? head.data[WIDTH-1:0] : '0;
        out_len     = out_valid ? head.len[LEN_W-1:0]  : '0;
    end

`ifdef ASSERT_ON
    a_hold_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> ($stable(out_data) && $stable(out_len)));

    a_len_nonzero: assert property (@(posedge clk) disable iff (rst)
        out_valid |-> (out_len != '0));
`endif

endmodule

// File: tb/tb_gate_bit_packer.sv
// Self-checking bench for gate_bit_packer (WIDTH=8) against a queue-based reference model.
module tb_gate_bit_packer;

    typedef struct {
        logic [7:0] data;
        logic [3:0] len;
    } word_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_bit;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [3:0] out_len;
    logic       overflow;
    logic [7:0] drop_count;

    int vectors     = 0;
    int miscompares = 0;

    bit    mq[$];
    word_t mf[$];
    logic  m_ovf  = 1'b0;
    int    m_drop = 0;

    gate_bit_packer #(.WIDTH(8), .DROP_CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_bit     (in_bit),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_len    (out_len),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    // Reference: bits gather in a queue; a word is the weighted sum of those bits.
    task automatic model_step();
        bit    do_pop;
        bit    do_emit;
        word_t w;
        if (rst) begin
            mq.delete();
            mf.delete();
            m_ovf  = 1'b0;
            m_drop = 0;
            return;
        end
        do_pop = (mf.size() > 0) && out_ready;
        if (in_valid) mq.push_back(in_bit);
        do_emit = (mq.size() == 8) || (flush && mq.size() > 0);
        if (do_pop) void'(mf.pop_front());
        if (do_emit) begin
            w.data = 8'd0;
            for (int i = 0; i < mq.size(); i++)
                if (mq[i]) w.data = w.data + 8'(1 << i);
            w.len = 4'(mq.size());
            if (mf.size() < 2) mf.push_back(w);
            else begin
                m_ovf = 1'b1;
                if (m_drop < 255) m_drop++;
            end
            mq.delete();
        end
    endtask

    task automatic tick(input logic v, input logic b, input logic f, input logic r);
        in_valid  = v;
        in_bit    = b;
        flush     = f;
        out_ready = r;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        #2;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", out_valid); end
        vectors++; if (out_data !== 8'h00) begin miscompares++; $display("FAIL reset_data got %h want 00", out_data); end
        vectors++; if (out_len !== 4'd0) begin miscompares++; $display("FAIL reset_len got %0d want 0", out_len); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_ovf got %b want 0", overflow); end
        vectors++; if (drop_count !== 8'd0) begin miscompares++; $display("FAIL reset_drop got %0d want 0", drop_count); end
        tick(0, 0, 0, 1);
        rst = 1'b0;
    endtask

    task automatic test_word();
        logic [7:0] pat = 8'b0100_1101;
        for (int i = 0; i < 8; i++) begin
            tick(1, pat[i], 0, 1);
            if (i == 6) begin
                vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL word_early got %b want 0", out_valid); end
            end
        end
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL word_valid got %b want 1", out_valid); end
        vectors++; if (out_data !== 8'h4D) begin miscompares++; $display("FAIL word_data got %h want 4d", out_data); end
        vectors++; if (out_len !== 4'd8) begin miscompares++; $display("FAIL word_len got %0d want 8", out_len); end
        tick(0, 0, 0, 1);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL word_oneshot got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) tick(1, 1, 0, 1);
        tick(0, 0, 1, 1);
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL flush_valid got %b want 1", out_valid); end
        vectors++; if (out_data !== 8'h07) begin miscompares++; $display("FAIL flush_data got %h want 07", out_data); end
        vectors++; if (out_len !== 4'd3) begin miscompares++; $display("FAIL flush_len got %0d want 3", out_len); end
        tick(0, 0, 1, 1);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_empty1 got %b want 0", out_valid); end
        tick(0, 0, 0, 1);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_empty2 got %b want 0", out_valid); end
    endtask

    task automatic test_overflow();
        logic [23:0] bits = 24'($urandom);
        for (int i = 0; i < 24; i++) tick(1, bits[i], 0, 0);
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL ovf_valid got %b want 1", out_valid); end
        vectors++; if (out_data !== bits[7:0]) begin miscompares++; $display("FAIL ovf_word0 got %h want %h", out_data, bits[7:0]); end
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag got %b want 1", overflow); end
        vectors++; if (drop_count !== 8'd1) begin miscompares++; $display("FAIL ovf_count got %0d want 1", drop_count); end
        tick(0, 0, 0, 1);
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL ovf_valid2 got %b want 1", out_valid); end
        vectors++; if (out_data !== bits[15:8]) begin miscompares++; $display("FAIL ovf_word1 got %h want %h", out_data, bits[15:8]); end
        tick(0, 0, 0, 1);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL ovf_drained got %b want 0", out_valid); end
    endtask

    task automatic test_flush_absorb();
        logic [7:0] pat = 8'($urandom);
        for (int i = 0; i < 7; i++) tick(1, pat[i], 0, 1);
        tick(1, pat[7], 1, 1);
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL absorb_valid got %b want 1", out_valid); end
        vectors++; if (out_len !== 4'd8) begin miscompares++; $display("FAIL absorb_len got %0d want 8", out_len); end
        vectors++; if (out_data !== pat) begin miscompares++; $display("FAIL absorb_data got %h want %h", out_data, pat); end
        tick(0, 0, 1, 1);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL absorb_empty got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [23:0] bits = 24'($urandom);
        for (int i = 0; i < 23; i++) tick(1, bits[i], 0, 0);
        tick(1, bits[23], 0, 1);
        vectors++; if (drop_count !== 8'd1) begin miscompares++; $display("FAIL b2b_nodrop got %0d want 1", drop_count); end
        vectors++; if (out_data !== bits[15:8]) begin miscompares++; $display("FAIL b2b_head got %h want %h", out_data, bits[15:8]); end
        tick(0, 0, 0, 0);
        vectors++; if (out_data !== bits[15:8]) begin miscompares++; $display("FAIL b2b_hold got %h want %h", out_data, bits[15:8]); end
        tick(0, 0, 0, 1);
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_occ got %b want 1", out_valid); end
        vectors++; if (out_data !== bits[23:16]) begin miscompares++; $display("FAIL b2b_word2 got %h want %h", out_data, bits[23:16]); end
        tick(0, 0, 0, 1);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drained got %b want 0", out_valid); end
    endtask

    task automatic test_mid_reset();
        logic [12:0] old_bits = 13'($urandom);
        logic [7:0]  fresh    = 8'($urandom);
        for (int i = 0; i < 13; i++) tick(1, old_bits[i], 0, 0);
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL mrst_pre got %b want 1", out_valid); end
        rst = 1'b1;
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mrst_valid got %b want 0", out_valid); end
        vectors++; if (out_data !== 8'h00) begin miscompares++; $display("FAIL mrst_data got %h want 00", out_data); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL mrst_ovf got %b want 0", overflow); end
        vectors++; if (drop_count !== 8'd0) begin miscompares++; $display("FAIL mrst_drop got %0d want 0", drop_count); end
        tick(0, 0, 0, 0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1, fresh[i], 0, 1);
            if (i == 6) begin
                vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mrst_stale got %b want 0", out_valid); end
            end
        end
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL mrst_new_valid got %b want 1", out_valid); end
        vectors++; if (out_data !== fresh) begin miscompares++; $display("FAIL mrst_new_data got %h want %h", out_data, fresh); end
        vectors++; if (out_len !== 4'd8) begin miscompares++; $display("FAIL mrst_new_len got %0d want 8", out_len); end
        tick(0, 0, 0, 1);
    endtask

    task automatic test_random();
        logic [7:0] e_data;
        logic [3:0] e_len;
        for (int n = 0; n < 400; n++) begin
            tick(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 2) != 0));
            e_data = (mf.size() > 0) ? mf[0].data : 8'h00;
            e_len  = (mf.size() > 0) ? mf[0].len  : 4'd0;
            vectors++; if (out_valid !== (mf.size() > 0)) begin miscompares++; $display("FAIL rnd_valid cyc %0d got %b want %b", n, out_valid, mf.size() > 0); end
            vectors++; if (out_data !== e_data) begin miscompares++; $display("FAIL rnd_data cyc %0d got %h want %h", n, out_data, e_data); end
            vectors++; if (out_len !== e_len) begin miscompares++; $display("FAIL rnd_len cyc %0d got %0d want %0d", n, out_len, e_len); end
            vectors++; if (overflow !== m_ovf) begin miscompares++; $display("FAIL rnd_ovf cyc %0d got %b want %b", n, overflow, m_ovf); end
            vectors++; if (drop_count !== 8'(m_drop)) begin miscompares++; $display("FAIL rnd_drop cyc %0d got %0d want %0d", n, drop_count, m_drop); end
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_word();
        test_flush();
        test_overflow();
        test_flush_absorb();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gate_bit_packer.md
GATE_BIT_PACKER -- requirements
Module: gate_bit_packer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bits per packed word; legal range 2..64.
REQ-002 SHALL have parameter DROP_CNT_W, default 8: width of the dropped-word counter.
REQ-003 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  a bit sample is present; it is driven from the upstream pipe's output_valid and has no backpressure.
REQ-006 SHALL have port in_bit  input  1  the sample value, driven from the upstream pipe's gated output.
REQ-007 SHALL have port flush  input  1  single-cycle request to emit a partial word.
REQ-008 SHALL have port out_valid  output  1  a packed word is available.
REQ-009 SHALL have port out_ready  input  1  the consumer accepts the word.
REQ-010 SHALL have port out_data  output  WIDTH  packed word; first-received bit in bit 0; unfilled bits are 0.
REQ-011 SHALL have port out_len  output  clog2(WIDTH+1)  number of valid bits in out_data, 1..WIDTH.
REQ-012 SHALL have port overflow  output  1  sticky: at least one word was dropped.
REQ-013 SHALL have port drop_count  output  DROP_CNT_W  count of dropped words; saturates at all-ones.

Function
REQ-014 SHALL store each in_valid sample at the current fill index of an accumulator, then increment the fill count.
REQ-015 SHALL complete a word in the cycle its fill count reaches WIDTH; the completed word (len=WIDTH) SHALL be written to the output buffer and the accumulator cleared, all in the same edge.
REQ-016 SHALL flush when flush=1 and fill count (including any same-cycle sample) is >0: emit the partial word with len=count and clear the accumulator.
REQ-017 SHALL treat flush with fill count 0 as a no-op and emit nothing.
REQ-018 SHALL, when flush coincides with the sample that completes a word, emit exactly one full word; the flush is absorbed.
REQ-019 SHALL use a 2-entry FIFO as the output buffer; out_valid=FIFO non-empty; out_data/out_len=head entry.
REQ-020 SHALL pop the FIFO only on out_valid&out_ready; out_data and out_len SHALL stay stable while out_valid&!out_ready.
REQ-021 SHALL accept a push into a full FIFO when a pop occurs in the same cycle.
REQ-022 SHALL, when a word completes or flushes while the FIFO is full and no pop occurs, drop that word: set overflow and increment drop_count (saturating); the accumulator still clears.
REQ-023 SHALL have a latency of 1 cycle: out_valid rises on the edge after the completing sample if the FIFO was empty.
REQ-024 SHALL give a sustained throughput of one word per WIDTH samples with out_ready held at 1, with no drops.
REQ-025 SHALL clear overflow and drop_count only on reset.

Reset
REQ-026 SHALL asynchronously clear, on rst=1: fill count, accumulator, FIFO pointers/occupancy, overflow, and drop_count.
REQ-027 SHALL drive out_valid=0, out_data=0, out_len=0, overflow=0, and drop_count=0 while in reset.
REQ-028 SHALL discard any partially filled word and any buffered words when reset is asserted mid-operation; nothing is emitted afterwards.
REQ-029 SHALL ignore in_valid and flush in the first edge after reset deassertion only if they are sampled while rst=1.

Structure
REQ-030 SHALL have package gate_pack_pkg hold the word-entry struct (data, len) and the localparam helper for the len width (clog2(WIDTH+1)).
REQ-031 SHALL implement the 2-entry FIFO as sub-module gate_pack_fifo2 (push/pop/full/empty, entry-typed data, async reset).
REQ-032 SHALL carry an assertion under ASSERT_ON requiring that out_data and out_len be held while out_valid&!out_ready.
REQ-033 SHALL carry an assertion under ASSERT_ON requiring that out_len never be 0 while out_valid=1.

Verification
REQ-034 SHALL verify: WIDTH=8, bits 1,0,1,1,0,0,1,0 on consecutive cycles, out_ready=1 -> one word, out_data=8'h4D, out_len=8, out_valid for 1 cycle, 1 cycle after the last bit.
REQ-035 SHALL verify: 3 bits 1,1,1, then flush -> out_data=8'h07, out_len=3; a second flush with 0 bits -> no output.
REQ-036 SHALL verify: out_ready=0, 24 consecutive samples -> 2 words buffered, third dropped, overflow=1, drop_count=1; then out_ready=1 -> the 2 buffered words are delivered in order.
REQ-037 SHALL verify: a flush on the cycle of the 8th bit -> exactly one word with out_len=8 and the accumulator empty.
REQ-038 SHALL verify: FIFO full, word completes on the same cycle as a pop -> no drop, and occupancy stays 2.
REQ-039 SHALL verify: reset asserted after 5 bits with 1 word buffered -> out_valid=0 immediately; 8 fresh bits after release produce one word holding only the new bits.
